// File: rtl/rocketcpu_audio_regbank.sv
// rocketcpu_audio_regbank
//
// Wishbone-slave register bank between the RocketCPU data bus and the audio
// datapath. The CPU writes N_PARAMS parameter registers with byte-lane
// enables. The audio core reads a set of read-only status snapshots that
// are captured from i_iparams on every i_sample_strobe.
//
// Optional feature macro: AUDIO_REGBANK_COMMIT_EN
//   defined   : parameters are double-buffered. CPU writes land in shadow
//               registers. A CTRL write arms a commit, and the next sample
//               strobe copies every shadow register into the live copy at
//               once.
//   undefined : there is no live copy. o_params shows the shadow registers
//               directly. The CTRL register is inert, and COMMIT_CNT counts
//               parameter writes instead of commits.
//
// Register map (byte addresses; only word-aligned addresses decode):
//   BASE_ADDR  + 4k     shadow parameter k          read/write
//   BASE_ADDR  + 0x100  CTRL  bit0 arm, bit1 abort   read {31'b0, pending}
//   BASE_ADDR  + 0x104  COMMIT_CNT (16 bit)          read-only
//   IBASE_ADDR + 4j     status snapshot j            read-only
//
// Ports:
//   i_wb_clk, i_wb_rst      clock, asynchronous active-high reset
//   i_wb_adr/dat/sel/we/cyc Wishbone request
//   o_wb_rdt, o_wb_ack      registered read data, one-cycle acknowledge
//   i_sample_strobe         one-cycle pulse per audio sample
//   o_params                live parameters, param k at [32k+31:32k]
//   i_iparams               raw status inputs, same flattening
//   o_commit_pending        a commit is armed
//   o_update                one-cycle pulse after the live parameters change
module rocketcpu_audio_regbank #(
  parameter int          N_PARAMS   = 16,
  parameter int          N_IPARAMS  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [31:0] IBASE_ADDR = 32'h1001_0000
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst,
  input  logic [31:0]             i_wb_adr,
  input  logic [31:0]             i_wb_dat,
  input  logic [3:0]              i_wb_sel,
  input  logic                    i_wb_we,
  input  logic                    i_wb_cyc,
  output logic [31:0]             o_wb_rdt,
  output logic                    o_wb_ack,
  input  logic                    i_sample_strobe,
  output logic [32*N_PARAMS-1:0]  o_params,
  input  logic [32*N_IPARAMS-1:0] i_iparams,
  output logic                    o_commit_pending,
  output logic                    o_update
);

  localparam int          PIDX_W  = (N_PARAMS  > 1) ? $clog2(N_PARAMS)  : 1;
  localparam int          IIDX_W  = (N_IPARAMS > 1) ? $clog2(N_IPARAMS) : 1;
  localparam logic [31:0] PWIN    = 32'(4 * N_PARAMS);
  localparam logic [31:0] IWIN    = 32'(4 * N_IPARAMS);
  localparam logic [31:0] CNT_OFS = 32'h104;

  logic [31:0]       r_shadow [N_PARAMS];
  logic [31:0]       r_snap   [N_IPARAMS];
  logic [15:0]       r_commitCnt;
  logic              r_ack;
  logic              r_update;
  logic [31:0]       r_rdt;

  logic [31:0]       w_ofs;
  logic [31:0]       w_iofs;
  logic              w_aligned;
  logic              w_access;
  logic              w_paramHit;
  logic              w_snapHit;
  logic              w_cntHit;
  logic              w_paramWr;
  logic [PIDX_W-1:0] w_pIdx;
  logic [IIDX_W-1:0] w_iIdx;
  logic [31:0]       w_rdData;

  // Address decode. An address below a base wraps to a huge offset, so a
  // single unsigned compare against the window size is enough.
  assign w_access   = i_wb_cyc & ~r_ack;
  assign w_ofs      = i_wb_adr - BASE_ADDR;
  assign w_iofs     = i_wb_adr - IBASE_ADDR;
  assign w_aligned  = (i_wb_adr[1:0] == 2'b00);
  assign w_paramHit = w_aligned && (w_ofs < PWIN);
  assign w_snapHit  = w_aligned && (w_iofs < IWIN);
  assign w_cntHit   = w_aligned && (w_ofs == CNT_OFS);
  assign w_pIdx     = w_ofs[PIDX_W+1:2];
  assign w_iIdx     = w_iofs[IIDX_W+1:2];
  assign w_paramWr  = w_access && i_wb_we && w_paramHit;

  // Bus handshake. Ack toggles off after one cycle so every access gets
  // exactly one write edge. Read data is captured on that same edge,
  // before any register update takes effect.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_ack <= 1'b0;
      r_rdt <= '0;
    end else begin
      r_ack <= i_wb_cyc & ~r_ack;
      if (w_access) begin
        r_rdt <= w_rdData;
      end
    end
  end

  // Shadow parameter writes, one byte lane at a time.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      for (int k = 0; k < N_PARAMS; k++) begin
        r_shadow[k] <= '0;
      end
    end else if (w_paramWr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) begin
          r_shadow[w_pIdx][8*b +: 8] <= i_wb_dat[8*b +: 8];
        end
      end
    end
  end

  // Status snapshots follow every sample strobe, independent of commits.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      for (int j = 0; j < N_IPARAMS; j++) begin
        r_snap[j] <= '0;
      end
    end else if (i_sample_strobe) begin
      for (int j = 0; j < N_IPARAMS; j++) begin
        r_snap[j] <= i_iparams[32*j +: 32];
      end
    end
  end

`ifdef AUDIO_REGBANK_COMMIT_EN
  localparam logic [31:0] CTRL_OFS = 32'h100;

  logic [31:0] r_live [N_PARAMS];
  logic        r_pending;
  logic        w_ctrlHit;
  logic        w_ctrlWr;
  logic        w_commit;

  assign w_ctrlHit = w_aligned && (w_ofs == CTRL_OFS);
  assign w_ctrlWr  = w_access && i_wb_we && w_ctrlHit && i_wb_sel[0];
  assign w_commit  = i_sample_strobe && r_pending;

  // Commit engine. The strobe samples the old pending flag, so an arm
  // written on the strobe edge waits for the next strobe. A CTRL write on
  // the same edge as a commit is applied after the commit clears pending.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      for (int k = 0; k < N_PARAMS; k++) begin
        r_live[k] <= '0;
      end
      r_pending   <= 1'b0;
      r_commitCnt <= '0;
      r_update    <= 1'b0;
    end else begin
      r_update <= w_commit;
      if (w_commit) begin
        for (int k = 0; k < N_PARAMS; k++) begin
          r_live[k] <= r_shadow[k];
        end
        r_pending   <= 1'b0;
        r_commitCnt <= r_commitCnt + 16'd1;
      end
      if (w_ctrlWr) begin
        if (i_wb_dat[1]) begin
          r_pending <= 1'b0;
        end else if (i_wb_dat[0]) begin
          r_pending <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_PARAMS; k++) begin : g_params
    assign o_params[32*k +: 32] = r_live[k];
  end
  assign o_commit_pending = r_pending;
`else
  // Without double-buffering, each accepted parameter write counts as an
  // update and becomes visible on the cycle after it is written.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      r_commitCnt <= '0;
      r_update    <= 1'b0;
    end else begin
      r_update <= w_paramWr;
      if (w_paramWr) begin
        r_commitCnt <= r_commitCnt + 16'd1;
      end
    end
  end

  for (genvar k = 0; k < N_PARAMS; k++) begin : g_params
    assign o_params[32*k +: 32] = r_shadow[k];
  end
  assign o_commit_pending = 1'b0;
`endif

  // Read mux. Unmapped or misaligned addresses read as zero.
  always_comb begin
    w_rdData = '0;
    if (w_paramHit) begin
      w_rdData = r_shadow[w_pIdx];
    end else if (w_snapHit) begin
      w_rdData = r_snap[w_iIdx];
    end else if (w_cntHit) begin
      w_rdData = {16'b0, r_commitCnt};
`ifdef AUDIO_REGBANK_COMMIT_EN
    end else if (w_ctrlHit) begin
      w_rdData = {31'b0, r_pending};
`endif
    end
  end

  assign o_wb_rdt = r_rdt;
  assign o_wb_ack = r_ack;
  assign o_update = r_update;

endmodule

// File: tb/tb_rocketcpu_audio_regbank.sv
// Testbench for rocketcpu_audio_regbank. A behavioural model of the register
// bank is stepped once per clock and compared with every DUT output after
// each edge. Directed test-plan steps are followed by a randomized phase.
module tb_rocketcpu_audio_regbank;
   localparam int          NP    = 16;
   localparam int          NI    = 4;
   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam logic [31:0] IBASE = 32'h1001_0000;
`ifdef AUDIO_REGBANK_COMMIT_EN
   localparam bit COMMIT_EN = 1'b1;
`else
   localparam bit COMMIT_EN = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [31:0]       adr = '0;
   logic [31:0]       dat = '0;
   logic [3:0]        sel = '0;
   logic              we = 1'b0;
   logic              cyc = 1'b0;
   logic              strobe = 1'b0;
   logic [32*NI-1:0]  iparams = '0;
   logic [31:0]       rdt;
   logic              ack;
   logic [32*NP-1:0]  params;
   logic              pending;
   logic              update;

   // Model state: the register file as seen from the bus.
   logic [31:0] mShadow [NP];
   logic [31:0] mLive   [NP];
   logic [31:0] mSnap   [NI];
   logic        mPending;
   logic [15:0] mCnt;
   logic        mAck;
   logic [31:0] mRdt;
   logic        mUpdate;

   int compareCount = 0;
   int failCount    = 0;

   always #5 clock = ~clock;

   rocketcpu_audio_regbank #(
      .N_PARAMS   (NP),
      .N_IPARAMS  (NI),
      .BASE_ADDR  (BASE),
      .IBASE_ADDR (IBASE)
   ) dut (
      .i_wb_clk         (clock),
      .i_wb_rst         (reset),
      .i_wb_adr         (adr),
      .i_wb_dat         (dat),
      .i_wb_sel         (sel),
      .i_wb_we          (we),
      .i_wb_cyc         (cyc),
      .o_wb_rdt         (rdt),
      .o_wb_ack         (ack),
      .i_sample_strobe  (strobe),
      .o_params         (params),
      .i_iparams        (iparams),
      .o_commit_pending (pending),
      .o_update         (update)
   );

   // Clear the whole model, as an asynchronous reset does.
   task automatic modelReset();
      for (int k = 0; k < NP; k++) begin
         mShadow[k] = '0;
         mLive[k]   = '0;
      end
      for (int j = 0; j < NI; j++) mSnap[j] = '0;
      mPending = 1'b0;
      mCnt     = '0;
      mAck     = 1'b0;
      mRdt     = '0;
      mUpdate  = 1'b0;
   endtask

   // Register map lookup by plain address arithmetic.
   function automatic logic [31:0] modelRead(input logic [31:0] a);
      int idx;
      if (a[1:0] != 2'b00) return 32'h0;
      if (a >= BASE && a < BASE + 32'(4*NP)) begin
         idx = int'((a - BASE) / 4);
         return mShadow[idx];
      end
      if (a >= IBASE && a < IBASE + 32'(4*NI)) begin
         idx = int'((a - IBASE) / 4);
         return mSnap[idx];
      end
      if (a == BASE + 32'h100) return COMMIT_EN ? {31'b0, mPending} : 32'h0;
      if (a == BASE + 32'h104) return {16'h0, mCnt};
      return 32'h0;
   endfunction

   function automatic logic [32*NP-1:0] expParams();
      logic [32*NP-1:0] v;
      for (int k = 0; k < NP; k++) v[32*k +: 32] = COMMIT_EN ? mLive[k] : mShadow[k];
      return v;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit          access;
      bit          commit;
      bit          paramWr;
      int          idx;
      logic [31:0] readVal;
      if (reset) begin
         modelReset();
         return;
      end
      access  = cyc && !mAck;
      readVal = modelRead(adr);
      paramWr = access && we && adr[1:0] == 2'b00 && adr >= BASE && adr < BASE + 32'(4*NP);
      commit  = COMMIT_EN && strobe && mPending;
      if (access) mRdt = readVal;
      mAck = access;
      if (commit) begin
         for (int k = 0; k < NP; k++) mLive[k] = mShadow[k];
         mPending = 1'b0;
         mCnt     = mCnt + 16'd1;
      end
      if (COMMIT_EN && access && we && adr == BASE + 32'h100 && sel[0]) begin
         if (dat[1]) mPending = 1'b0;
         else if (dat[0]) mPending = 1'b1;
      end
      if (paramWr) begin
         idx = int'((adr - BASE) / 4);
         for (int b = 0; b < 4; b++)
            if (sel[b]) mShadow[idx][8*b +: 8] = dat[8*b +: 8];
         if (!COMMIT_EN) mCnt = mCnt + 16'd1;
      end
      mUpdate = COMMIT_EN ? commit : paramWr;
      if (strobe)
         for (int j = 0; j < NI; j++) mSnap[j] = iparams[32*j +: 32];
   endtask

   task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      compareCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll();
      checkOutput("ack", 512'(ack), 512'(mAck));
      checkOutput("rdt", 512'(rdt), 512'(mRdt));
      checkOutput("params", 512'(params), 512'(expParams()));
      checkOutput("pending", 512'(pending), 512'(mPending));
      checkOutput("update", 512'(update), 512'(mUpdate));
   endtask

   // One clock: model and DUT see the same inputs, outputs sampled 1ns later.
   task automatic applyStimulus();
      modelStep();
      @(posedge clock);
      #1;
      checkAll();
   endtask

   task automatic busAccess(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic w, input logic strobeFirst);
      cyc = 1'b1; adr = a; dat = d; sel = s; we = w; strobe = strobeFirst;
      applyStimulus();
      cyc = 1'b0; we = 1'b0; strobe = 1'b0;
      applyStimulus();
   endtask

   task automatic pulseStrobe();
      strobe = 1'b1;
      applyStimulus();
      strobe = 1'b0;
      applyStimulus();
   endtask

   initial begin
      logic [31:0] ra;
      int          cls;

      // Reset and the all-zero register map.
      modelReset();
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      applyStimulus();
      busAccess(BASE + 32'h08, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_param2_reset", 512'(rdt), 512'(32'h0));
      busAccess(BASE + 32'h100, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_ctrl_reset", 512'(rdt), 512'(32'h0));
      busAccess(BASE + 32'h104, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_cnt_reset", 512'(rdt), 512'(32'h0));
      busAccess(IBASE, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_snap_reset", 512'(rdt), 512'(32'h0));
      checkOutput("params_reset", 512'(params), 512'(0));

      // Byte-lane write, then an armed commit.
      busAccess(BASE + 32'h04, 32'hDEADBEEF, 4'b0101, 1'b1, 1'b0);
      busAccess(BASE + 32'h04, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_shadow1", 512'(rdt), 512'(32'h00AD00EF));
      checkOutput("live1_before", 512'(params[63:32]), 512'(COMMIT_EN ? 32'h0 : 32'h00AD00EF));
      busAccess(BASE + 32'h100, 32'h1, 4'hF, 1'b1, 1'b0);
      applyStimulus();
      pulseStrobe();
      checkOutput("live1_after", 512'(params[63:32]), 512'(32'h00AD00EF));
      busAccess(BASE + 32'h104, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("cnt_one", 512'(rdt), 512'(32'h1));

      // Arm on the strobe edge: the commit waits for the following strobe.
      busAccess(BASE + 32'h08, 32'h11112222, 4'hF, 1'b1, 1'b0);
      busAccess(BASE + 32'h100, 32'h1, 4'hF, 1'b1, 1'b1);
      checkOutput("live2_wait", 512'(params[95:64]), 512'(COMMIT_EN ? 32'h0 : 32'h11112222));
      pulseStrobe();
      checkOutput("live2_after", 512'(params[95:64]), 512'(32'h11112222));
      busAccess(BASE + 32'h104, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("cnt_two", 512'(rdt), 512'(32'h2));

      // Arm then abort: no commit happens.
      busAccess(BASE + 32'h0C, 32'h33334444, 4'hF, 1'b1, 1'b0);
      busAccess(BASE + 32'h100, 32'h1, 4'hF, 1'b1, 1'b0);
      busAccess(BASE + 32'h100, 32'h3, 4'hF, 1'b1, 1'b0);
      busAccess(BASE + 32'h100, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_ctrl_abort", 512'(rdt), 512'(32'h0));
      pulseStrobe();
      busAccess(BASE + 32'h104, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("cnt_abort", 512'(rdt), 512'(COMMIT_EN ? 32'h2 : 32'h3));

      // Snapshot coherence and ignored writes to read-only/misaligned addresses.
      iparams[31:0] = 32'h1234;
      pulseStrobe();
      iparams[31:0] = 32'h5678;
      busAccess(IBASE, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_snap0", 512'(rdt), 512'(32'h1234));
      cyc = 1'b1; adr = IBASE; dat = 32'hFFFFFFFF; sel = 4'hF; we = 1'b1;
      applyStimulus();
      checkOutput("ack_ro_write", 512'(ack), 512'(1'b1));
      cyc = 1'b0; we = 1'b0;
      applyStimulus();
      busAccess(32'h1000_0002, 32'hAAAAAAAA, 4'hF, 1'b1, 1'b0);
      busAccess(IBASE, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_snap0_kept", 512'(rdt), 512'(32'h1234));
      busAccess(BASE, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("rd_param0_kept", 512'(rdt), 512'(32'h0));

      // Randomized traffic, strobes and status inputs.
      for (int n = 0; n < 250; n++) begin
         cls = int'($urandom_range(0, 6));
         case (cls)
            0, 1: ra = BASE + 32'(4 * $urandom_range(0, NP - 1));
            2:    ra = BASE + 32'h100;
            3:    ra = BASE + 32'h104;
            4:    ra = IBASE + 32'(4 * $urandom_range(0, NI - 1));
            5:    ra = BASE + 32'($urandom_range(0, 32'h200));
            default: ra = IBASE + 32'($urandom_range(0, 32'h40));
         endcase
         if ($urandom_range(0, 3) == 0) iparams = {$urandom, $urandom, $urandom, $urandom};
         busAccess(ra, (cls == 2) ? 32'($urandom_range(0, 3)) : $urandom, 4'($urandom),
                   1'($urandom), ($urandom_range(0, 3) == 0));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            strobe = ($urandom_range(0, 2) == 0);
            applyStimulus();
         end
         strobe = 1'b0;
      end

      // Three commits, then reset in the middle of an access.
      for (int c = 0; c < 3; c++) begin
         busAccess(BASE + 32'(4 * c), $urandom | 32'h1, 4'hF, 1'b1, 1'b0);
         busAccess(BASE + 32'h100, 32'h1, 4'hF, 1'b1, 1'b0);
         pulseStrobe();
      end
      cyc = 1'b1; adr = BASE; dat = 32'hCAFEF00D; sel = 4'hF; we = 1'b1;
      #2;
      reset = 1'b1;
      applyStimulus();
      checkOutput("ack_in_reset", 512'(ack), 512'(1'b0));
      checkOutput("params_in_reset", 512'(params), 512'(0));
      cyc = 1'b0; we = 1'b0;
      applyStimulus();
      reset = 1'b0;
      applyStimulus();
      busAccess(BASE + 32'h104, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("cnt_after_reset", 512'(rdt), 512'(32'h0));
      busAccess(BASE, '0, 4'hF, 1'b0, 1'b0);
      checkOutput("shadow_after_reset", 512'(rdt), 512'(32'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end
endmodule
